// File: rtl/rv32i_instr_encoder_pkg.sv
// rtl/rv32i_instr_encoder_pkg.sv - shared RV32I opcodes, NOP word, immediate limits and word type
package rv32i_instr_encoder_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_field_pack.sv
// rtl/rv32i_instr_encoder_field_pack.sv - combinational format selection and immediate range check
module rv32i_field_pack
  import rv32i_instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output enc_word_t   word
);

  logic imm12_ok;
  logic imm13_ok;

  assign imm12_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
  // Branch offsets must also be halfword aligned.
  assign imm13_ok = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];

  always_comb begin
    word.instr = NOP;
    word.err   = 1'b1;
    case (opcode)
      OP_R: begin
        word.instr = {funct7, rs2, rs1, funct3, rd, opcode};
        word.err   = 1'b0;
      end
      OP_I, OP_LOAD: begin
        if (imm12_ok) begin
          word.instr = {imm[11:0], rs1, funct3, rd, opcode};
          word.err   = 1'b0;
        end
      end
      OP_S: begin
        if (imm12_ok) begin
          word.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
          word.err   = 1'b0;
        end
      end
      OP_B: begin
        if (imm13_ok) begin
          word.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
          word.err   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I field encoder with 2-entry skid output buffer and counters
module rv32i_instr_encoder
  import rv32i_instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  enc_word_t  packed_word;
  enc_word_t  e0;
  enc_word_t  e1;
  logic [1:0] occ;
  logic [1:0] occ_next;
  logic       push;
  logic       pop;

  rv32i_field_pack u_field_pack (
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .word   (packed_word)
  );

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign instr     = e0.instr;
  assign err       = e0.err;

  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ - 2'd1;
    end
  end

  // e0 is always the head; e1 is cleared on pop so an empty buffer presents instr=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      e0        <= '0;
      e1        <= '0;
      occ       <= 2'd0;
      in_ready  <= 1'b1;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      occ      <= occ_next;
      in_ready <= (occ_next != 2'd2);
      if (pop) begin
        if (push && occ == 2'd1) begin
          e0 <= packed_word;
        end else begin
          e0 <= e1;
        end
        e1 <= (push && occ == 2'd2) ? packed_word : '0;
        if (enc_count != '1) begin
          enc_count <= enc_count + CNT_ONE;
        end
        if (e0.err && err_count != '1) begin
          err_count <= err_count + CNT_ONE;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          e0 <= packed_word;
        end else begin
          e1 <= packed_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - directed self-checking bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int tests;
  int fails;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] im;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  rv32i_instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // addi x(k+1), x2, 3k
  function automatic logic [31:0] stream_word(input int k);
    logic [11:0] i12;
    logic [4:0]  d;
    i12 = 12'(k * 3);
    d   = 5'(k + 1);
    return {i12, 5'd2, 3'd0, d, 7'h13};
  endfunction

  task automatic test_reset;
    in_valid = 1'b0; out_ready = 1'b1;
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 00000000", instr); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (enc_count !== '0) begin fails++; $display("FAIL reset_enc_count got %0d want 0", enc_count); end
    tests++; if (err_count !== '0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_encode;
    vec_t v[15];
    logic [CNT_W-1:0] snap;
    v[0]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF10093, 1'b0};
    v[1]  = '{7'h23, 5'd31, 5'd2, 5'd5, 3'd2, 7'h00, 32'd8, 32'h00512423, 1'b0};
    v[2]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0};
    v[3]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFD, 32'h00000013, 1'b1};
    v[4]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h00000013, 1'b1};
    v[5]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0, 32'h00000013, 1'b1};
    v[6]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd12345, 32'h002081B3, 1'b0};
    v[7]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0};
    v[8]  = '{7'h03, 5'd6, 5'd1, 5'd0, 3'd2, 7'h00, 32'd4, 32'h0040A303, 1'b0};
    v[9]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2047, 32'h7FF10093, 1'b0};
    v[10] = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h80010093, 1'b0};
    v[11] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4094, 32'h7E208FE3, 1'b0};
    v[12] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_F000, 32'h80208063, 1'b0};
    v[13] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4096, 32'h00000013, 1'b1};
    v[14] = '{7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFF_F7FF, 32'h00000013, 1'b1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_fields(v[i].op, v[i].d, v[i].s1, v[i].s2, v[i].f3, v[i].f7, v[i].im);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL enc%0d_out_valid got %b want 1", i, out_valid); end
      tests++; if (instr !== v[i].exp_instr) begin fails++; $display("FAIL enc%0d_instr got %h want %h", i, instr, v[i].exp_instr); end
      tests++; if (err !== v[i].exp_err) begin fails++; $display("FAIL enc%0d_err got %b want %b", i, err, v[i].exp_err); end
      snap = err_count;
      tick();
      tests++;
      if (err_count !== snap + CNT_W'(v[i].exp_err)) begin
        fails++; $display("FAIL enc%0d_err_count got %0d want %0d", i, err_count, snap + CNT_W'(v[i].exp_err));
      end
    end
    tests++; if (enc_count !== 4'd15) begin fails++; $display("FAIL enc_total got %0d want 15", enc_count); end
    tests++; if (err_count !== 4'd5) begin fails++; $display("FAIL err_total got %0d want 5", err_count); end
  endtask

  task automatic test_stream;
    logic [3:0] pat;
    int sent, got, occ;
    logic acc, del;
    pat = 4'b1001;
    sent = 0; got = 0; occ = 0;
    do_reset();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = pat[3 - (cyc % 4)];
      in_valid  = (sent < 8);
      set_fields(7'h13, 5'(sent + 1), 5'd2, 5'd0, 3'd0, 7'h00, 32'(sent * 3));
      tests++; if (in_ready !== (occ != 2)) begin fails++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, in_ready, occ != 2); end
      tests++; if (out_valid !== (occ != 0)) begin fails++; $display("FAIL stream_out_valid cyc %0d got %b want %b", cyc, out_valid, occ != 0); end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        tests++;
        if (instr !== stream_word(got) || err !== 1'b0) begin
          fails++; $display("FAIL stream_word%0d got %h/%b want %h/0", got, instr, err, stream_word(got));
        end
        got++;
      end
      tick();
      sent += int'(acc);
      occ  += int'(acc) - int'(del);
    end
    in_valid = 1'b0;
    tests++; if (got != 8) begin fails++; $display("FAIL stream_delivered got %0d want 8", got); end
    tests++; if (enc_count !== 4'd8) begin fails++; $display("FAIL stream_enc_count got %0d want 8", enc_count); end
  endtask

  task automatic test_saturation;
    do_reset();
    out_ready = 1'b1;
    set_fields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++; if (enc_count !== 4'hF) begin fails++; $display("FAIL sat_enc_count got %0d want 15", enc_count); end
    tests++; if (err_count !== 4'hF) begin fails++; $display("FAIL sat_err_count got %0d want 15", err_count); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_ready = 1'b0;
    set_fields(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd5);
    in_valid = 1'b1;
    tick();
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_full_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_full_out_valid got %b want 1", out_valid); end
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    tests++; if (enc_count !== '0 || err_count !== '0) begin fails++; $display("FAIL mid_counters got %0d/%0d want 0/0", enc_count, err_count); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL mid_instr got %h want 00000000", instr); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_void_handshake got %b want 0", out_valid); end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0);
    test_reset();
    test_encode();
    test_stream();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
